hazard_unit: RTL and testbench

- Load-use hazard detection unit for the 5-stage RV32I pipeline.
- Compares the destination register of a load in ID/EX against the source registers of the instruction in IF/ID.
- On a match it freezes the PC and the IF/ID register and injects a bubble into ID/EX, giving exactly one stall cycle per hazard.
- Also keeps a registered, saturating count of stall cycles for performance monitoring.

---
 rtl/hazard_unit_pkg.sv | 9 +
 rtl/hazard_unit_reg_match.sv | 19 +
 rtl/hazard_unit.sv | 70 +++++++
 tb/tb_hazard_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register-index width and the x0 constant,
// used by the hazard unit and the forwarding unit.
package hazard_unit_pkg;

  localparam int          REG_ADDR_W  = 5;
  localparam int          STALL_CNT_W = 32;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_reg_match.sv
// Register-index comparator: flags when an enabled producer writes a
// non-x0 register that a consumer source field names.
module reg_match #(
  parameter int W = 5
) (
  input  logic         en,
  input  logic [W-1:0] rd,
  input  logic [W-1:0] rs,
  output logic         match
);

  import hazard_unit_pkg::*;

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  always_comb begin
    match = en && (rd != W'(REG_ZERO)) && (rd == rs);
  end

endmodule : reg_match

// File: rtl/hazard_unit.sv
// Load-use hazard detection. A load in ID/EX whose destination is read by
// the instruction in IF/ID freezes PC and IF/ID and bubbles ID/EX for one
// cycle. No stall state is kept: once the bubble reaches ID/EX its memRead
// is 0 and the hazard drops by itself. A saturating counter records the
// number of stalled cycles; reset only clears that counter.
module hazard_unit #(
  parameter int REG_ADDR_W = hazard_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = hazard_unit_pkg::STALL_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_memRead,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_count
);

  logic             match_rs1;
  logic             match_rs2;
  logic             hazard;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;

  // Source fields are compared whether or not the instruction uses them;
  // an occasional spurious stall is the accepted cost of not decoding.
  reg_match #(.W(REG_ADDR_W)) u_match_rs1 (
    .en    (id_ex_memRead),
    .rd    (id_ex_rd),
    .rs    (if_id_rs1),
    .match (match_rs1)
  );

  reg_match #(.W(REG_ADDR_W)) u_match_rs2 (
    .en    (id_ex_memRead),
    .rd    (id_ex_rd),
    .rs    (if_id_rs2),
    .match (match_rs2)
  );

  // Stall controls are purely combinational and independent of rst.
  always_comb begin
    hazard      = match_rs1 || match_rs2;
    stall_pc    = hazard;
    stall_if_id = hazard;
    flush_id_ex = hazard;
    stall_count = stall_count_q;
  end

  // Next counter value: count stalled cycles, stick at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a driver applies one input vector per cycle on the
// falling edge and pushes the model's expectation; a monitor pops and
// compares just after each rising edge. A second instance with a 4-bit
// counter exercises saturation in a few cycles.
module tb_hazard_unit;

  localparam int RW    = 5;
  localparam int CW    = 32;
  localparam int CW_S  = 4;
  localparam int EXP_W = 1 + CW + CW_S;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_ex_memRead;
  logic [RW-1:0] id_ex_rd;
  logic [RW-1:0] if_id_rs1;
  logic [RW-1:0] if_id_rs2;
  logic          stall_pc, stall_if_id, flush_id_ex;
  logic [CW-1:0] stall_count;
  logic          stall_pc_s, stall_if_id_s, flush_id_ex_s;
  logic [CW_S-1:0] stall_count_s;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  longint m_cnt   = 0;
  longint m_cnt_s = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_ex_memRead (id_ex_memRead),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .flush_id_ex   (flush_id_ex),
    .stall_count   (stall_count)
  );

  hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW_S)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .id_ex_memRead (id_ex_memRead),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .stall_pc      (stall_pc_s),
    .stall_if_id   (stall_if_id_s),
    .flush_id_ex   (flush_id_ex_s),
    .stall_count   (stall_count_s)
  );

  // ---------------- reference model ----------------
  // A load stalls a consumer that reads its non-zero destination.
  function automatic bit model_hazard(bit mr, int rd, int rs1, int rs2);
    return mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // ---------------- checker ----------------
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(bit r, bit mr, int rd, int rs1, int rs2);
    bit     h;
    longint max_l = (64'd1 << CW) - 1;
    longint max_s = (64'd1 << CW_S) - 1;
    @(negedge clk);
    rst           = r;
    id_ex_memRead = mr;
    id_ex_rd      = RW'(rd);
    if_id_rs1     = RW'(rs1);
    if_id_rs2     = RW'(rs2);
    h = model_hazard(mr, rd, rs1, rs2);
    if (r) begin
      m_cnt   = 0;
      m_cnt_s = 0;
    end else if (h) begin
      if (m_cnt < max_l)   m_cnt++;
      if (m_cnt_s < max_s) m_cnt_s++;
    end
    exp_q.push_back({h, CW'(m_cnt), CW_S'(m_cnt_s)});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    bit               e_h;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        e_h = e[EXP_W-1];
        check("stall_pc",      longint'(stall_pc),      longint'(e_h));
        check("stall_if_id",   longint'(stall_if_id),   longint'(e_h));
        check("flush_id_ex",   longint'(flush_id_ex),   longint'(e_h));
        check("stall_pc_sat",  longint'(stall_pc_s),    longint'(e_h));
        check("stall_count",   longint'(stall_count),   longint'(e[CW_S +: CW]));
        check("stall_count_sat", longint'(stall_count_s), longint'(e[CW_S-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int wait_cycles;
    rst = 1'b1;
    id_ex_memRead = 1'b0;
    id_ex_rd = '0;
    if_id_rs1 = '0;
    if_id_rs2 = '0;

    // Combinational outputs respond before any clock edge.
    id_ex_memRead = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9;
    #1;
    check("comb_before_clock", longint'(stall_pc), 1);
    id_ex_memRead = 1'b0;
    #1;
    check("comb_memread0", longint'(flush_id_ex), 0);

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 5, 5, 0);      // no load, no stall
    drive(0, 1, 0, 0, 0);      // x0 never stalls
    drive(0, 1, 10, 10, 0);    // rs1 match, count 1..3
    drive(0, 1, 10, 10, 0);
    drive(0, 1, 10, 10, 0);
    drive(0, 1, 7, 0, 7);      // rs2 match
    drive(0, 1, 7, 7, 7);      // both match, single stall
    drive(0, 1, 3, 1, 2);      // no match, count holds
    drive(0, 1, 3, 1, 2);
    drive(1, 1, 10, 10, 0);    // reset mid-stall, outputs still high
    for (int i = 0; i < 20; i++) drive(0, 1, 10, 10, 0);  // small counter saturates
    drive(0, 1, 31, 31, 31);   // top register index
    drive(0, 0, 31, 31, 31);

    // Randomized phase with biased register indices to hit matches often.
    for (int i = 0; i < 300; i++) begin
      int rd, rs1, rs2;
      bit r;
      r   = ($urandom_range(0, 29) == 0);
      rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      rs1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      rs2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      drive(r, 1'($urandom_range(0, 1)), rd, rs1, rs2);
    end

    // Drain: the monitor must consume everything within a few cycles.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_unit
